// File: rtl/maxnet_pkg.sv
// Shared types for the Maxnet winner detector.
//   status_t : result code presented on o_status
//   state_t  : control FSM state encoding
package maxnet_pkg;

  typedef enum logic [1:0] {
    ST_NONE     = 2'd0,
    ST_WIN      = 2'd1,
    ST_ALL_ZERO = 2'd2,
    ST_TIMEOUT  = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/maxnet_zero_scan.sv
// Combinational zero scan over N activation channels.
// Ports:
//   i_x_bus    : N channels of W bits, channel i at [i*W +: W]
//   o_nz       : per-channel nonzero flag
//   o_one_hot  : exactly one channel nonzero
//   o_all_zero : every channel zero
//   o_idx      : binary index of the lowest nonzero channel (0 if none)
// IGNORE_SIGN=1 treats a value with only the top (sign) bit set as zero.
module maxnet_zero_scan #(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 32,
  parameter bit          IGNORE_SIGN = 1'b1,
  localparam int unsigned IdxW       = $clog2(N)
) (
  input  logic [N*W-1:0]  i_x_bus,
  output logic [N-1:0]    o_nz,
  output logic            o_one_hot,
  output logic            o_all_zero,
  output logic [IdxW-1:0] o_idx
);

  for (genvar g = 0; g < N; g++) begin : g_chan
    logic [W-1:0] w_ch;
    assign w_ch = i_x_bus[g*W +: W];
    // Sign bit only matters when signed zero is not folded into zero.
    assign o_nz[g] = (w_ch[W-2:0] != '0) || (!IGNORE_SIGN && w_ch[W-1]);
  end

  // A nonzero vector with a single bit set has no bits left after clearing the lowest one.
  assign o_one_hot  = (o_nz != '0) && ((o_nz & (o_nz - {{(N-1){1'b0}}, 1'b1})) == '0);
  assign o_all_zero = (o_nz == '0);

  always_comb begin
    o_idx = '0;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (o_nz[i]) o_idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/maxnet_winner_detect.sv
// Maxnet winner detector: watches N activation channels once per iteration and
// declares WIN (single nonzero channel), ALL_ZERO, or TIMEOUT after MAX_ITER samples.
// The result is held with o_done until i_ack.
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_start            : begin a run (IDLE only)
//   i_in_valid         : i_x_bus/i_a_bus carry one iteration sample
//   i_x_bus, i_a_bus   : activations / associated values, channel i at [i*W +: W]
//   i_ack              : consumer took the result
//   o_busy, o_done     : in RUN / in DONE
//   o_status           : NONE, WIN, ALL_ZERO, TIMEOUT
//   o_winner_idx/_val  : winning channel index and associated value
//   o_iter_cnt         : samples consumed in current or last run
// Build option: define CONFIRM_WIN_EN to require two consecutive same-index
// one-hot samples before declaring WIN.
module maxnet_winner_detect
  import maxnet_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 32,
  parameter bit          IGNORE_SIGN = 1'b1,
  parameter int unsigned MAX_ITER    = 255,
  parameter int unsigned IW          = $clog2(MAX_ITER + 1),
  localparam int unsigned IdxW       = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_in_valid,
  input  logic [N*W-1:0]  i_x_bus,
  input  logic [N*W-1:0]  i_a_bus,
  input  logic            i_ack,
  output logic            o_busy,
  output logic            o_done,
  output logic [1:0]      o_status,
  output logic [IdxW-1:0] o_winner_idx,
  output logic [W-1:0]    o_winner_val,
  output logic [IW-1:0]   o_iter_cnt
);

  localparam logic [IW-1:0] MaxIterC = IW'(MAX_ITER);
  localparam logic [IW-1:0] OneC     = IW'(1);

  state_t          r_state, w_state_d;
  status_t         r_status, w_status_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic [W-1:0]    r_val, w_val_d;
  logic [IW-1:0]   r_iter, w_iter_d, w_iter_inc;

  logic [N-1:0]    w_nz;
  logic            w_one_hot, w_all_zero, w_win;
  logic [IdxW-1:0] w_idx;
  logic [W-1:0]    w_a_sel;

  maxnet_zero_scan #(
    .N           (N),
    .W           (W),
    .IGNORE_SIGN (IGNORE_SIGN)
  ) u_scan (
    .i_x_bus    (i_x_bus),
    .o_nz       (w_nz),
    .o_one_hot  (w_one_hot),
    .o_all_zero (w_all_zero),
    .o_idx      (w_idx)
  );

  assign w_a_sel    = i_a_bus[int'(w_idx)*W +: W];
  assign w_iter_inc = (r_iter == MaxIterC) ? r_iter : r_iter + OneC;

`ifdef CONFIRM_WIN_EN
  logic            r_cand_vld, w_cand_vld_d;
  logic [IdxW-1:0] r_cand_idx, w_cand_idx_d;
  assign w_win = w_one_hot && r_cand_vld && (r_cand_idx == w_idx);
`else
  assign w_win = w_one_hot;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_status   <= ST_NONE;
      r_idx      <= '0;
      r_val      <= '0;
      r_iter     <= '0;
`ifdef CONFIRM_WIN_EN
      r_cand_vld <= 1'b0;
      r_cand_idx <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_status   <= w_status_d;
      r_idx      <= w_idx_d;
      r_val      <= w_val_d;
      r_iter     <= w_iter_d;
`ifdef CONFIRM_WIN_EN
      r_cand_vld <= w_cand_vld_d;
      r_cand_idx <= w_cand_idx_d;
`endif
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_status_d   = r_status;
    w_idx_d      = r_idx;
    w_val_d      = r_val;
    w_iter_d     = r_iter;
`ifdef CONFIRM_WIN_EN
    w_cand_vld_d = r_cand_vld;
    w_cand_idx_d = r_cand_idx;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_d    = S_RUN;
          w_status_d   = ST_NONE;
          w_iter_d     = '0;
`ifdef CONFIRM_WIN_EN
          w_cand_vld_d = 1'b0;
          w_cand_idx_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (i_in_valid) begin
          w_iter_d = w_iter_inc;
`ifdef CONFIRM_WIN_EN
          // A one-hot sample always (re)arms the candidate; anything else clears it.
          w_cand_vld_d = w_one_hot;
          w_cand_idx_d = w_one_hot ? w_idx : r_cand_idx;
`endif
          // Convergence outranks timeout on the same sample.
          if (w_win) begin
            w_status_d = ST_WIN;
            w_idx_d    = w_idx;
            w_val_d    = w_a_sel;
            w_state_d  = S_DONE;
          end else if (w_all_zero) begin
            w_status_d = ST_ALL_ZERO;
            w_idx_d    = '0;
            w_val_d    = '0;
            w_state_d  = S_DONE;
          end else if (w_iter_inc == MaxIterC) begin
            w_status_d = ST_TIMEOUT;
            w_state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_ack) w_state_d = S_IDLE;
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign o_busy       = (r_state == S_RUN);
  assign o_done       = (r_state == S_DONE);
  assign o_status     = r_status;
  assign o_winner_idx = r_idx;
  assign o_winner_val = r_val;
  assign o_iter_cnt   = r_iter;

endmodule
